// File: rtl/de2drums_pkg.sv
// Shared definitions for the DE2 drum machine: instrument count, sequencer
// FSM state encoding and instrument index constants.
package de2drums_pkg;

  localparam int NUM_INS = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PLAY  = ST_PLAY,
    PAUSE = ST_PAUSE
  } seq_state_t;

  localparam logic [1:0] INS1 = 2'd0;
  localparam logic [1:0] INS2 = 2'd1;
  localparam logic [1:0] INS3 = 2'd2;
  localparam logic [1:0] INS4 = 2'd3;

endpackage

// File: rtl/drum_step_sequencer_if.sv
// Pattern-row write handshake between the switch-entry control FSM (master)
// and the step sequencer (slave).
interface drum_step_sequencer_if #(
  parameter int STEPS = 16
);

  logic             wr_en;
  logic [1:0]       wr_ins;
  logic [STEPS-1:0] wr_data;
  logic             wr_ack;

  modport master (output wr_en, output wr_ins, output wr_data, input wr_ack);
  modport slave  (input wr_en, input wr_ins, input wr_data, output wr_ack);

endinterface

// File: rtl/drum_step_sequencer_trig_stretch.sv
// Holds one instrument trigger high for LEN cycles after each pulse; a new
// pulse while held restarts the count, clear drops it at once.
module trig_stretch #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic pulse,
  output logic held
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (pulse) begin
      count <= CW'(LEN);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign held = (count != '0);

endmodule

// File: rtl/drum_step_sequencer.sv
// Four-instrument step sequencer with play/pause/stop FSM and pattern rows.
// Optional macro TRIG_STRETCH_EN widens each trigger to TRIG_LEN cycles.
module drum_step_sequencer
  import de2drums_pkg::*;
#(
  parameter int STEPS    = 16,
  parameter int TRIG_LEN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     play_req,
  input  logic                     pause_req,
  input  logic                     stop_req,
  drum_step_sequencer_if.slave     wr,
  output logic [NUM_INS-1:0]       trig,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     playing
);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [STEPS-1:0] pattern [NUM_INS];
  logic             sound;
  logic [NUM_INS-1:0] hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Priority stop > pause > play; requests invalid for a state fall through.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (play_req) next_state = PLAY;
      PLAY: begin
        if (stop_req)       next_state = IDLE;
        else if (pause_req) next_state = PAUSE;
      end
      PAUSE: begin
        if (stop_req)      next_state = IDLE;
        else if (play_req) next_state = PLAY;
      end
      default: next_state = IDLE;
    endcase
  end

  // A tick only sounds when PLAY is kept; any state change swallows it.
  assign sound = (state == PLAY) && (next_state == PLAY) && tick;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_INS; i++) begin
      hit[i] = sound && pattern[i][step];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step <= '0;
    end else if (state == IDLE || next_state == IDLE) begin
      step <= '0;
    end else if (sound) begin
      step <= step + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) playing <= 1'b0;
    else        playing <= (next_state == PLAY);
  end

  // The trigger reads pattern before this write lands, so a same-cycle
  // write only affects the following tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INS; i++) pattern[i] <= '0;
    end else if (wr.wr_en) begin
      pattern[wr.wr_ins] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr.wr_ack <= 1'b0;
    else        wr.wr_ack <= wr.wr_en;
  end

`ifdef TRIG_STRETCH_EN
  for (genvar g = 0; g < NUM_INS; g++) begin : g_stretch
    trig_stretch #(.LEN(TRIG_LEN)) u_stretch (
      .clk   (clk),
      .reset (reset),
      .clear (stop_req),
      .pulse (hit[g]),
      .held  (trig[g])
    );
  end
`else
  // A zero TRIG_LEN mutes the outputs; otherwise triggers are 1-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trig <= '0;
    else        trig <= (TRIG_LEN > 0) ? hit : '0;
  end
`endif

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer: directed scenarios plus a
// random phase, all compared against a behavioural model of the sequencer.
module tb_drum_step_sequencer;
  import de2drums_pkg::*;

  localparam int STEPS    = 16;
  localparam int TRIG_LEN = 4;
  localparam int SW       = $clog2(STEPS);
  localparam int M_IDLE   = 0;
  localparam int M_PLAY   = 1;
  localparam int M_PAUSE  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic play_req = 1'b0;
  logic pause_req = 1'b0;
  logic stop_req = 1'b0;
  logic [NUM_INS-1:0] trig;
  logic [SW-1:0]      step;
  logic               playing;

  drum_step_sequencer_if #(.STEPS(STEPS)) wr_if ();

  drum_step_sequencer #(.STEPS(STEPS), .TRIG_LEN(TRIG_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .play_req  (play_req),
    .pause_req (pause_req),
    .stop_req  (stop_req),
    .wr        (wr_if),
    .trig      (trig),
    .step      (step),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int                 m_state;
  int                 m_step;
  logic [STEPS-1:0]   m_pat [NUM_INS];
  logic [NUM_INS-1:0] m_trig;
  logic               m_ack;
  logic               m_playing;
  int                 m_hold [NUM_INS];

  task automatic model_reset();
    m_state = M_IDLE;
    m_step = 0;
    for (int i = 0; i < NUM_INS; i++) begin
      m_pat[i] = '0;
      m_hold[i] = 0;
    end
    m_trig = '0;
    m_ack = 1'b0;
    m_playing = 1'b0;
  endtask

  task automatic model_edge(input logic t, input logic pl, input logic pa,
                            input logic st, input logic we,
                            input logic [1:0] wi, input logic [STEPS-1:0] wd);
    logic [NUM_INS-1:0] fired;
    fired = '0;
    case (m_state)
      M_PLAY: begin
        if (st) begin
          m_state = M_IDLE;
          m_step = 0;
        end else if (pa) begin
          m_state = M_PAUSE;
        end else if (t) begin
          for (int i = 0; i < NUM_INS; i++) fired[i] = m_pat[i][m_step];
          m_step = (m_step + 1) % STEPS;
        end
      end
      M_PAUSE: begin
        if (st) begin
          m_state = M_IDLE;
          m_step = 0;
        end else if (pl) begin
          m_state = M_PLAY;
        end
      end
      default: begin
        if (pl) begin
          m_state = M_PLAY;
          m_step = 0;
        end
      end
    endcase
    if (we) m_pat[wi] = wd;
    m_ack = we;
    m_playing = (m_state == M_PLAY);
`ifdef TRIG_STRETCH_EN
    for (int i = 0; i < NUM_INS; i++) begin
      if (st)            m_hold[i] = 0;
      else if (fired[i]) m_hold[i] = TRIG_LEN;
      else if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
      m_trig[i] = (m_hold[i] > 0);
    end
`else
    m_trig = fired;
`endif
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".trig"},    32'(trig),         32'(m_trig));
    check_val({tag, ".step"},    32'(step),         32'(m_step));
    check_val({tag, ".playing"}, 32'(playing),      32'(m_playing));
    check_val({tag, ".wr_ack"},  32'(wr_if.wr_ack), 32'(m_ack));
  endtask

  task automatic apply_stimulus(input logic t, input logic pl, input logic pa,
                                input logic st, input logic we,
                                input logic [1:0] wi, input logic [STEPS-1:0] wd,
                                input string tag);
    tick = t;
    play_req = pl;
    pause_req = pa;
    stop_req = st;
    wr_if.wr_en = we;
    wr_if.wr_ins = wi;
    wr_if.wr_data = wd;
    @(posedge clk);
    model_edge(t, pl, pa, st, we, wi, wd);
    @(negedge clk);
    tick = 1'b0;
    play_req = 1'b0;
    pause_req = 1'b0;
    stop_req = 1'b0;
    wr_if.wr_en = 1'b0;
    check_output(tag);
  endtask

  task automatic do_idle(input string tag);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, tag);
  endtask

  task automatic do_tick(input string tag);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, tag);
  endtask

  task automatic do_play(input string tag);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, tag);
  endtask

  task automatic write_row(input logic [1:0] ins, input logic [STEPS-1:0] data, input string tag);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ins, data, tag);
  endtask

  initial begin
    wr_if.wr_en = 1'b0;
    wr_if.wr_ins = 2'd0;
    wr_if.wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("reset");
    reset = 1'b1;
    do_idle("post_reset");

    // Scenario 1: single hits on first and last step, wrap 15 -> 0.
    write_row(INS1, 16'h0001, "t1_wr0");
    check_val("t1_ack", 32'(wr_if.wr_ack), 32'd1);
    write_row(INS2, 16'h8000, "t1_wr1");
    do_play("t1_play");
    check_val("t1_playing", 32'(playing), 32'd1);
    for (int k = 1; k <= STEPS; k++) begin
      do_tick("t1_tick");
      if (k == 1) check_val("t1_first_trig", 32'(trig), 32'h1);
      if (k == STEPS) begin
        check_val("t1_last_trig", 32'(trig), 32'h2);
        check_val("t1_wrap", 32'(step), 32'd0);
      end
    end

    // Scenario 2: pause at step 5, ticks ignored, resume.
    for (int k = 0; k < 5; k++) do_tick("t2_run");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, "t2_pause");
    check_val("t2_paused", 32'(playing), 32'd0);
    for (int k = 0; k < 3; k++) do_tick("t2_paused_tick");
    check_val("t2_held_step", 32'(step), 32'd5);
    do_play("t2_resume");
    check_val("t2_replaying", 32'(playing), 32'd1);
    do_tick("t2_tick");
    check_val("t2_step6", 32'(step), 32'd6);

    // Scenario 3: pause + stop + tick together, stop wins.
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, '0, "t3_stop");
    check_val("t3_step0", 32'(step), 32'd0);
    check_val("t3_idle", 32'(playing), 32'd0);

    // Scenario 4: write row 2 on the same cycle as the tick at step 3.
    do_play("t4_play");
    for (int k = 0; k < 3; k++) do_tick("t4_run");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, INS3, 16'hFFFF, "t4_wr_tick");
    check_val("t4_old_row", 32'(trig[2]), 32'd0);
    check_val("t4_ack", 32'(wr_if.wr_ack), 32'd1);
    do_tick("t4_next");
    check_val("t4_new_row", 32'(trig[2]), 32'd1);

    // Random phase: mixed requests, ticks and writes.
    for (int k = 0; k < 400; k++) begin
      apply_stimulus(1'($urandom % 2), 1'($urandom % 8 == 0), 1'($urandom % 10 == 0),
                     1'($urandom % 16 == 0), 1'($urandom % 4 == 0),
                     2'($urandom % 4), 16'($urandom), "rand");
    end

    // Scenario 5: asynchronous reset mid-bar with triggers active.
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0, "t5_stop");
    for (int i = 0; i < NUM_INS; i++) write_row(2'(i), 16'hFFFF, "t5_wr");
    do_play("t5_play");
    for (int k = 0; k < 3; k++) do_tick("t5_run");
    check_val("t5_trig_live", 32'(trig), 32'hF);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_output("t5_async");
    @(negedge clk);
    reset = 1'b1;
    do_play("t5_replay");
    for (int k = 0; k < STEPS; k++) do_tick("t5_cleared_rows");

`ifdef TRIG_STRETCH_EN
    // Scenario 6: stretched trigger stays high with ticks two cycles apart.
    write_row(INS1, 16'hFFFF, "t6_wr");
    for (int k = 0; k < 6; k++) begin
      do_tick("t6_tick");
      check_val("t6_held_a", 32'(trig[0]), 32'd1);
      do_idle("t6_gap");
      check_val("t6_held_b", 32'(trig[0]), 32'd1);
    end
    for (int k = 0; k < 5; k++) do_idle("t6_decay");
    check_val("t6_low", 32'(trig[0]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
